// File: rtl/keypad_multiplier.sv
// keypad_multiplier
//   Keypad-driven 4x4-bit sequential multiplier. Each debounced one-hot row
//   press on fila is encoded as a 2-bit code (row index). Four presses build
//   operand A (high pair, low pair) then operand B; a shift-add datapath then
//   multiplies them over four cycles and the 8-bit product is held on m until
//   the next result completes.
//
//   Optional build macro: MULT_SIGNED_EN
//     defined   -> operands are 4-bit two's complement, m is the 8-bit
//                  two's-complement product (sign-magnitude around the same
//                  unsigned shift-add core, identical latency)
//     undefined -> unsigned 4x4 -> 8 multiplication
//
// Parameters
//   DEBOUNCE_CYCLES : cycles the synchronized row value must stay unchanged
//                     before it becomes the stable value (1..255)
//   SYNC_STAGES     : flip-flop depth of the fila synchronizer (2..3)
//
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   fila : keypad row lines, active-high, bit i = row i pressed
//   m    : product register, last completed result
module keypad_multiplier #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fila,
    output logic [7:0] m
);

    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        A_HI,
        A_LO,
        B_HI,
        B_LO,
        MULT,
        DONE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [3:0] sync_q [SYNC_STAGES];
    logic [3:0] sync_out;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= fila;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce: track follows the synchronized value; any change restarts
    // the count. Once the tracked value has been seen unchanged for
    // DEBOUNCE_CYCLES cycles it is copied to stable.
    // ------------------------------------------------------------------
    logic [3:0] track_q;
    logic [7:0] deb_cnt_q;
    logic [3:0] stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            track_q   <= '0;
            deb_cnt_q <= '0;
            stable_q  <= '0;
        end else if (sync_out != track_q) begin
            track_q   <= sync_out;
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            stable_q <= track_q;
        end else begin
            deb_cnt_q <= deb_cnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Press detection and key encoding
    // ------------------------------------------------------------------
    logic       stable_one_hot;
    logic [1:0] stable_code;
    logic [3:0] accepted_q;
    logic       press_q;
    logic [1:0] code_q;

    always_comb begin
        stable_one_hot = (stable_q != 4'b0000) &&
                         ((stable_q & (stable_q - 4'd1)) == 4'b0000);
        stable_code = 2'd0;
        unique case (stable_q)
            4'b0010: stable_code = 2'd1;
            4'b0100: stable_code = 2'd2;
            4'b1000: stable_code = 2'd3;
            default: stable_code = 2'd0;
        endcase
    end

    // accepted_q updates in the same cycle the pulse is raised, so a held
    // key cannot retrigger; a release or a different row re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            accepted_q <= '0;
            press_q    <= 1'b0;
            code_q     <= '0;
        end else begin
            press_q <= 1'b0;
            if (stable_one_hot && (stable_q != accepted_q)) begin
                press_q    <= 1'b1;
                code_q     <= stable_code;
                accepted_q <= stable_q;
            end else if (stable_q == 4'b0000) begin
                accepted_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Operand magnitude / sign preparation for the B_LO -> MULT load
    // ------------------------------------------------------------------
    state_t     state_q;
    logic [3:0] a_q;
    logic [1:0] b_hi_q;
    logic [7:0] mcand_q;
    logic [3:0] mplier_q;
    logic [7:0] acc_q;
    logic [1:0] iter_q;
    logic [7:0] m_q;

    logic [3:0] b_full;
    logic [3:0] a_mag;
    logic [3:0] b_mag;
    logic [7:0] result;

`ifdef MULT_SIGNED_EN
    logic neg_q;

    // Magnitude of -8 is 4'b1000, which still fits the unsigned core.
    always_comb begin
        b_full = {b_hi_q, code_q};
        a_mag  = a_q[3]    ? (~a_q + 4'd1)    : a_q;
        b_mag  = b_full[3] ? (~b_full + 4'd1) : b_full;
        result = neg_q ? (~acc_q + 8'd1) : acc_q;
    end
`else
    always_comb begin
        b_full = {b_hi_q, code_q};
        a_mag  = a_q;
        b_mag  = b_full;
        result = acc_q;
    end
`endif

    // ------------------------------------------------------------------
    // Entry / multiply FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= A_HI;
            a_q      <= '0;
            b_hi_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            iter_q   <= '0;
            m_q      <= '0;
`ifdef MULT_SIGNED_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                A_HI: begin
                    if (press_q) begin
                        a_q[3:2] <= code_q;
                        state_q  <= A_LO;
                    end
                end
                A_LO: begin
                    if (press_q) begin
                        a_q[1:0] <= code_q;
                        state_q  <= B_HI;
                    end
                end
                B_HI: begin
                    if (press_q) begin
                        b_hi_q  <= code_q;
                        state_q <= B_LO;
                    end
                end
                B_LO: begin
                    // The completing press loads the datapath directly, so
                    // MULT starts iterating on the very next cycle.
                    if (press_q) begin
                        mcand_q  <= {4'b0000, a_mag};
                        mplier_q <= b_mag;
                        acc_q    <= '0;
                        iter_q   <= '0;
`ifdef MULT_SIGNED_EN
                        neg_q    <= a_q[3] ^ b_full[3];
`endif
                        state_q  <= MULT;
                    end
                end
                MULT: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= {mcand_q[6:0], 1'b0};
                    mplier_q <= {1'b0, mplier_q[3:1]};
                    iter_q   <= iter_q + 2'd1;
                    if (iter_q == 2'd3) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    m_q     <= result;
                    state_q <= A_HI;
                end
                default: state_q <= A_HI;
            endcase
        end
    end

    assign m = m_q;

endmodule

// File: tb/tb_keypad_multiplier.sv
module tb_keypad_multiplier;

    logic       clk;
    logic       rst;
    logic [3:0] fila;
    logic [7:0] m;

    int checks   = 0;
    int failures = 0;

    keypad_multiplier #(
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .fila (fila),
        .m    (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Drive a row pattern and hold it for n cycles.
    task automatic drive(input logic [3:0] row, input int n);
        fila = row;
        tick(n);
    endtask

    initial begin
        rst  = 1'b1;
        fila = 4'b0000;

        // ---------------- Reset ----------------
        tick(1);
        check("reset_m_c1", m, 8'h00);
        tick(4);
        check("reset_m_c5", m, 8'h00);
        tick(5);
        check("reset_m_c10", m, 8'h00);
        rst = 1'b0;
        tick(20);
        check("idle_no_press", m, 8'h00);

        // ---------------- Basic 2*2, direct row changes ----------------
        drive(4'b0001, 10);
        drive(4'b0100, 10);
        drive(4'b0001, 10);
        check("basic_before_b_lo", m, 8'h00);
        drive(4'b0100, 10);
        tick(10);
        check("basic_2x2", m, 8'h04);
        // Two more presses only load A; m must hold.
        drive(4'b0001, 10);
        drive(4'b0100, 20);
        check("basic_hold_after_a", m, 8'h04);

        // ---------------- Reset clears m and entry ----------------
        fila = 4'b0000;
        rst  = 1'b1;
        tick(1);
        check("reset2_m", m, 8'h00);
        tick(2);
        rst = 1'b0;
        tick(10);

        // ---------------- Hold/release: A=1110, B=1111 ----------------
        drive(4'b1000, 50);           // long hold: one press only
        drive(4'b0000, 10);
        drive(4'b0100, 10);
        drive(4'b1000, 10);
        check("hr_partial", m, 8'h00);
        drive(4'b0000, 10);
        drive(4'b1000, 10);
        drive(4'b0000, 20);
`ifdef MULT_SIGNED_EN
        check("hr_neg2_x_neg1", m, 8'h02);
`else
        check("hr_14x15", m, 8'hD2);
`endif

        // ---------------- Glitch and multi-hot rejection ----------------
        drive(4'b0001, 2);            // shorter than debounce
        drive(4'b0000, 20);
`ifdef MULT_SIGNED_EN
        check("glitch_m", m, 8'h02);
`else
        check("glitch_m", m, 8'hD2);
`endif
        drive(4'b0011, 30);           // stable multi-hot
        drive(4'b0000, 20);
        // FSM must still be in A_HI for this to give 2*2.
        drive(4'b0001, 10);
        drive(4'b0100, 10);
        drive(4'b0001, 10);
        drive(4'b0100, 10);
        drive(4'b0000, 20);
        check("after_invalid_2x2", m, 8'h04);

        // ---------------- Reset mid-entry ----------------
        drive(4'b0010, 10);
        drive(4'b1000, 10);
        fila = 4'b0000;
        rst  = 1'b1;
        tick(1);
        check("reset_mid_m", m, 8'h00);
        tick(2);
        rst = 1'b0;
        tick(10);
        // A=1100, B=0110
        drive(4'b1000, 10);
        drive(4'b0001, 10);
        drive(4'b0010, 10);
        drive(4'b0100, 10);
        drive(4'b0000, 20);
`ifdef MULT_SIGNED_EN
        check("restart_neg4_x_6", m, 8'hE8);
`else
        check("restart_12x6", m, 8'h48);
`endif

        // ---------------- Max operands: A=B=1111 ----------------
        for (int i = 0; i < 4; i++) begin
            drive(4'b1000, 10);
            drive(4'b0000, 10);
        end
        tick(10);
`ifdef MULT_SIGNED_EN
        check("max_neg1_x_neg1", m, 8'h01);
`else
        check("max_15x15", m, 8'hE1);
`endif

        // ---------------- Zero operand: A=0000, B=1111 ----------------
        drive(4'b0001, 10);
        drive(4'b0000, 10);
        drive(4'b0001, 10);
        drive(4'b1000, 10);
        drive(4'b0000, 10);
        drive(4'b1000, 10);
        drive(4'b0000, 20);
        check("zero_x_max", m, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_multiplier.md
Name: keypad_multiplier

Overview:
- Keypad-driven 4x4-bit sequential multiplier.
- Accepts debounced one-hot keypad row presses on `fila` and encodes each press as a 2-bit code.
- Assembles two 4-bit operands from four consecutive presses, multiplies them with a shift-add datapath, and holds the 8-bit product on `m`.
- Top-level block of the keypad/arithmetic subsystem.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized row value must stay unchanged before it is accepted (range 1..255).
- SYNC_STAGES, 2, depth of the input synchronizer on `fila` (range 2..3).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- fila  input  4  keypad row lines, active-high; bit i set = key on row i pressed.
- m  output  8  product register; holds the last completed result.

Behaviour:
- Reset:
  - Synchronous, active-high, single clock domain.
  - While rst=1: m=8'h00, synchronizer and debounce state cleared, accepted-row register=4'b0000, FSM in A_HI, operand registers cleared.
  - Reset asserted mid-entry or mid-multiply aborts the operation; m=0 on the next edge.
- Input path:
  - `fila` passes through SYNC_STAGES flip-flops.
  - A debounce counter restarts whenever the synchronized value changes.
  - When the value has been unchanged for DEBOUNCE_CYCLES cycles it becomes the "stable" value.
- Press detection:
  - A press event is a single-cycle pulse generated when the stable value is exactly one-hot AND differs from the last accepted row value.
  - Accepted row value then updates to the stable value.
  - Stable 4'b0000 (release) sets accepted value to 0; no event.
  - Multi-hot stable values: ignored, accepted value unchanged.
  - Direct change from one row to another (e.g. 0001 to 0100 without release) counts as a new press.
  - Holding a key generates only one event.
- Key code: row0 gives 2'd0, row1 gives 2'd1, row2 gives 2'd2, row3 gives 2'd3.
- FSM states: A_HI, A_LO, B_HI, B_LO, MULT, DONE.
  - A_HI: on event, A[3:2]=code, go to A_LO.
  - A_LO: on event, A[1:0]=code, go to B_HI.
  - B_HI / B_LO: likewise fill B[3:2] then B[1:0]. The event in B_LO goes to MULT.
  - MULT: 4 iterations, one per cycle. Each iteration:
    - if multiplier LSB=1, acc += multiplicand;
    - multiplicand shifts left;
    - multiplier shifts right.
  - DONE: m <= acc[7:0] for one cycle, then go to A_HI.
- Latency: m updates 5 clocks after the press event that completes B (4 MULT + 1 DONE).
- Press events in MULT/DONE are discarded.
- m holds its value through subsequent operand entry until the next DONE.
- Arithmetic: unsigned 4x4 to 8 bits, no overflow possible (max 15*15=225).

Optional Feature:
- Macro: MULT_SIGNED_EN.
- Defined:
  - A and B are 4-bit two's complement (-8..7).
  - Product is the 8-bit two's-complement result (range -56..64).
  - Implement via sign-magnitude conversion or a Booth step; latency must remain 5 cycles.
- Undefined: unsigned multiplication as specified above.

Test Plan:
- Reset: hold rst=1 for 10 cycles with fila=0 -> m=8'h00, no press events.
- Basic multiply: presses 0001,0100,0001,0100 (no releases; each held 10 cycles) -> A=2, B=2; m=8'h04 five cycles after the fourth press is accepted.
  - Two further presses (0001, 0100) then only load A; m stays 8'h04.
- Hold/release: rows 1000, release, 0100, then 1000, release, 1000, release, 1000, release, 1000 -> A=14, B=15, m=8'hD2.
  - A key held 50 cycles yields exactly one press.
- Glitch/debounce and invalid input: fila pulse shorter than DEBOUNCE_CYCLES -> no event, FSM state unchanged.
  - Stable multi-hot 0011 -> no event, FSM state unchanged.
- Reset mid-operation: assert rst after two presses of a new entry -> m=8'h00 next edge.
  - Entry restarts at A_HI: the next four presses 0001,0100,0001,0100 produce m=8'h04.
- MULT_SIGNED_EN build: codes for A=4'b1110 (row3 then row2) and B=4'b1111 (row3, release, row3) -> m=8'h02.
  - Same sequence without the macro -> m=8'hD2.
